// File: rtl/ps_loop_ctrl.sv
// Nested hardware loop controller for the program sequencer.
// Keeps a small stack of {start, end, count} entries, watches the fetch
// address against the innermost loop end and issues a one-cycle fetch
// redirect back to the loop start until the count runs out. Up to two
// stacked loops that share one end address are resolved in a single cycle.
module ps_loop_ctrl #(
  parameter int DEPTH = 4,
  parameter int AW    = 16,
  parameter int CW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          lp_push,
  input  logic [AW-1:0] lp_start_add,
  input  logic [AW-1:0] lp_end_add,
  input  logic [CW-1:0] lp_cnt,
  input  logic          lp_pop,
  input  logic [AW-1:0] faddr,
  input  logic          fetch_vld,
  input  logic          lc_clr,
  output logic          lc_redir,
  output logic [AW-1:0] lc_redir_add,
  output logic [CW-1:0] lc_curlcntr,
  output logic [AW-1:0] lc_laddr,
  output logic [3:0]    lc_depth,
  output logic          lc_busy,
  output logic          lc_ovf,
  output logic          lc_unf
);

  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [AW-1:0] ADDR_ONE  = AW'(1);
  localparam logic [3:0]    DEPTH_MAX = 4'(DEPTH);

  // Stack storage; entries at or above depth_r are don't-care.
  logic [AW-1:0] start_r [DEPTH];
  logic [AW-1:0] end_r   [DEPTH];
  logic [CW-1:0] cnt_r   [DEPTH];
  logic [3:0]    depth_r;

  // Next-state view of the stack.
  logic [AW-1:0] start_s [DEPTH];
  logic [AW-1:0] end_s   [DEPTH];
  logic [CW-1:0] cnt_s   [DEPTH];
  logic [3:0]    depth_s;

  logic          redir_s;
  logic [AW-1:0] redir_add_s;
  logic          ovf_set_s;
  logic          unf_set_s;
  logic          match_go_s;
  logic [AW-1:0] lvl_start_s;
  logic [AW-1:0] lvl_end_s;
  logic [CW-1:0] lvl_cnt_s;
  logic [AW-1:0] top_end_s;
  logic [CW-1:0] top_cnt_s;

  // Next-state computation: pop/abort, up to two end-match levels, then push.
  always_comb begin
    start_s     = start_r;
    end_s       = end_r;
    cnt_s       = cnt_r;
    depth_s     = depth_r;
    redir_s     = 1'b0;
    redir_add_s = '0;
    ovf_set_s   = 1'b0;
    unf_set_s   = 1'b0;
    match_go_s  = 1'b0;
    lvl_start_s = '0;
    lvl_end_s   = '0;
    lvl_cnt_s   = '0;
    top_end_s   = '0;
    top_cnt_s   = '0;

    if (!stall) begin
      if (lp_pop) begin
        // An abort wins over any end match in the same cycle.
        if (depth_r != 4'd0) begin
          depth_s = depth_r - 4'd1;
        end else begin
          unf_set_s = 1'b1;
        end
      end else begin
        match_go_s = fetch_vld;
        for (int lv = 0; lv < 2; lv++) begin
          lvl_start_s = '0;
          lvl_end_s   = '0;
          lvl_cnt_s   = '0;
          for (int i = 0; i < DEPTH; i++) begin
            if ((depth_s != 4'd0) && (4'(i) == depth_s - 4'd1)) begin
              lvl_start_s = start_s[i];
              lvl_end_s   = end_s[i];
              lvl_cnt_s   = cnt_s[i];
            end else begin
              lvl_start_s = lvl_start_s;
            end
          end
          if (match_go_s && (depth_s != 4'd0) && (lvl_end_s == faddr)) begin
            if (lvl_cnt_s > CNT_ONE) begin
              // Loop again: decrement and redirect; outer levels are untouched.
              for (int i = 0; i < DEPTH; i++) begin
                if (4'(i) == depth_s - 4'd1) begin
                  cnt_s[i] = lvl_cnt_s - CNT_ONE;
                end else begin
                  cnt_s[i] = cnt_s[i];
                end
              end
              redir_s     = 1'b1;
              redir_add_s = lvl_start_s;
              match_go_s  = 1'b0;
            end else begin
              // Last pass: drop this level and let the next one look at faddr.
              depth_s = depth_s - 4'd1;
            end
          end else begin
            match_go_s = 1'b0;
          end
        end
      end

      if (lp_push) begin
        if (lp_cnt == '0) begin
          // Zero-trip loop: skip the body; overrides any end-match redirect.
          redir_s     = 1'b1;
          redir_add_s = lp_end_add + ADDR_ONE;
        end else if (depth_s == DEPTH_MAX) begin
          ovf_set_s = 1'b1;
        end else begin
          for (int i = 0; i < DEPTH; i++) begin
            if (4'(i) == depth_s) begin
              start_s[i] = lp_start_add;
              end_s[i]   = lp_end_add;
              cnt_s[i]   = lp_cnt;
            end else begin
              start_s[i] = start_s[i];
            end
          end
          depth_s = depth_s + 4'd1;
        end
      end else begin
        depth_s = depth_s;
      end
    end else begin
      depth_s = depth_r;
    end

    for (int i = 0; i < DEPTH; i++) begin
      if ((depth_s != 4'd0) && (4'(i) == depth_s - 4'd1)) begin
        top_end_s = end_s[i];
        top_cnt_s = cnt_s[i];
      end else begin
        top_end_s = top_end_s;
      end
    end
  end

  // State and registered outputs; stall freezes everything and masks redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        start_r[i] <= '0;
        end_r[i]   <= '0;
        cnt_r[i]   <= '0;
      end
      depth_r      <= 4'd0;
      lc_redir     <= 1'b0;
      lc_redir_add <= '0;
      lc_curlcntr  <= '0;
      lc_laddr     <= '0;
      lc_depth     <= 4'd0;
      lc_busy      <= 1'b0;
      lc_ovf       <= 1'b0;
      lc_unf       <= 1'b0;
    end else if (stall) begin
      lc_redir <= 1'b0;
    end else begin
      start_r     <= start_s;
      end_r       <= end_s;
      cnt_r       <= cnt_s;
      depth_r     <= depth_s;
      lc_redir    <= redir_s;
      if (redir_s) begin
        lc_redir_add <= redir_add_s;
      end else begin
        lc_redir_add <= lc_redir_add;
      end
      lc_curlcntr <= top_cnt_s;
      lc_laddr    <= top_end_s;
      lc_depth    <= depth_s;
      lc_busy     <= (depth_s != 4'd0);
      lc_ovf      <= ovf_set_s | (lc_ovf & ~lc_clr);
      lc_unf      <= unf_set_s | (lc_unf & ~lc_clr);
    end
  end

endmodule

// File: tb/tb_ps_loop_ctrl.sv
// Directed bench for ps_loop_ctrl: single, nested, zero-trip, overflow,
// underflow, stall, simultaneous requests and reset mid-loop.
module tb_ps_loop_ctrl;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        lp_push;
  logic [15:0] lp_start_add;
  logic [15:0] lp_end_add;
  logic [15:0] lp_cnt;
  logic        lp_pop;
  logic [15:0] faddr;
  logic        fetch_vld;
  logic        lc_clr;
  logic        lc_redir;
  logic [15:0] lc_redir_add;
  logic [15:0] lc_curlcntr;
  logic [15:0] lc_laddr;
  logic [3:0]  lc_depth;
  logic        lc_busy;
  logic        lc_ovf;
  logic        lc_unf;

  int checks;
  int failures;

  ps_loop_ctrl #(.DEPTH(4), .AW(16), .CW(16)) dut (
    .clk(clk), .rst(rst), .stall(stall), .lp_push(lp_push),
    .lp_start_add(lp_start_add), .lp_end_add(lp_end_add), .lp_cnt(lp_cnt),
    .lp_pop(lp_pop), .faddr(faddr), .fetch_vld(fetch_vld), .lc_clr(lc_clr),
    .lc_redir(lc_redir), .lc_redir_add(lc_redir_add), .lc_curlcntr(lc_curlcntr),
    .lc_laddr(lc_laddr), .lc_depth(lc_depth), .lc_busy(lc_busy),
    .lc_ovf(lc_ovf), .lc_unf(lc_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock; outputs are sampled 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] s, input logic [15:0] e, input logic [15:0] c);
    lp_push = 1'b1; lp_start_add = s; lp_end_add = e; lp_cnt = c;
    cyc();
    lp_push = 1'b0;
  endtask

  task automatic pop();
    lp_pop = 1'b1;
    cyc();
    lp_pop = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cyc(); cyc(); rst = 1'b0;
    checks++; if (lc_depth !== 4'd0) begin failures++; $display("FAIL reset_depth got=%0h exp=0", lc_depth); end
    checks++; if (lc_redir !== 1'b0 || lc_redir_add !== 16'h0) begin failures++; $display("FAIL reset_redir got=%0b/%0h exp=0/0", lc_redir, lc_redir_add); end
    checks++; if (lc_ovf !== 1'b0 || lc_unf !== 1'b0 || lc_busy !== 1'b0) begin failures++; $display("FAIL reset_flags got ovf=%0b unf=%0b busy=%0b exp=0", lc_ovf, lc_unf, lc_busy); end
    checks++; if (lc_curlcntr !== 16'h0 || lc_laddr !== 16'h0) begin failures++; $display("FAIL reset_top got=%0h/%0h exp=0/0", lc_curlcntr, lc_laddr); end
  endtask

  task automatic test_single();
    logic [15:0] exp_cnt;
    push(16'h0010, 16'h0013, 16'd3);
    checks++; if (lc_depth !== 4'd1 || lc_curlcntr !== 16'd3 || lc_laddr !== 16'h0013 || lc_busy !== 1'b1) begin failures++; $display("FAIL single_push got d=%0h c=%0h l=%0h exp=1/3/13", lc_depth, lc_curlcntr, lc_laddr); end
    fetch_vld = 1'b1;
    for (int pass = 1; pass <= 3; pass++) begin
      for (int a = 16'h10; a <= 16'h12; a++) begin
        faddr = 16'(a); cyc();
        checks++; if (lc_redir !== 1'b0) begin failures++; $display("FAIL single_body_redir pass=%0d addr=%0h got=%0b exp=0", pass, a, lc_redir); end
      end
      faddr = 16'h0013; cyc();
      if (pass < 3) begin
        exp_cnt = 16'(3 - pass);
        checks++; if (lc_redir !== 1'b1 || lc_redir_add !== 16'h0010 || lc_curlcntr !== exp_cnt) begin failures++; $display("FAIL single_redir pass=%0d got r=%0b a=%0h c=%0h exp=1/10/%0h", pass, lc_redir, lc_redir_add, lc_curlcntr, exp_cnt); end
      end else begin
        checks++; if (lc_redir !== 1'b0 || lc_depth !== 4'd0 || lc_curlcntr !== 16'h0 || lc_laddr !== 16'h0) begin failures++; $display("FAIL single_exit got r=%0b d=%0h c=%0h l=%0h exp=0/0/0/0", lc_redir, lc_depth, lc_curlcntr, lc_laddr); end
      end
    end
    fetch_vld = 1'b0;
  endtask

  task automatic test_nested();
    push(16'h0020, 16'h0028, 16'd2);
    push(16'h0024, 16'h0028, 16'd2);
    checks++; if (lc_depth !== 4'd2 || lc_curlcntr !== 16'd2) begin failures++; $display("FAIL nest_setup got d=%0h c=%0h exp=2/2", lc_depth, lc_curlcntr); end
    fetch_vld = 1'b1; faddr = 16'h0028; cyc();
    checks++; if (lc_redir !== 1'b1 || lc_redir_add !== 16'h0024 || lc_curlcntr !== 16'd1) begin failures++; $display("FAIL nest_r1 got r=%0b a=%0h c=%0h exp=1/24/1", lc_redir, lc_redir_add, lc_curlcntr); end
    faddr = 16'h0026; cyc();
    checks++; if (lc_redir !== 1'b0) begin failures++; $display("FAIL nest_pulse got=%0b exp=0", lc_redir); end
    faddr = 16'h0028; cyc();
    checks++; if (lc_redir !== 1'b1 || lc_redir_add !== 16'h0020 || lc_depth !== 4'd1 || lc_curlcntr !== 16'd1) begin failures++; $display("FAIL nest_r2 got r=%0b a=%0h d=%0h c=%0h exp=1/20/1/1", lc_redir, lc_redir_add, lc_depth, lc_curlcntr); end
    fetch_vld = 1'b0;
    push(16'h0024, 16'h0028, 16'd2);
    fetch_vld = 1'b1; faddr = 16'h0028; cyc();
    checks++; if (lc_redir !== 1'b1 || lc_redir_add !== 16'h0024 || lc_depth !== 4'd2) begin failures++; $display("FAIL nest_r3 got r=%0b a=%0h d=%0h exp=1/24/2", lc_redir, lc_redir_add, lc_depth); end
    faddr = 16'h0028; cyc();
    checks++; if (lc_redir !== 1'b0 || lc_depth !== 4'd0) begin failures++; $display("FAIL nest_exit got r=%0b d=%0h exp=0/0", lc_redir, lc_depth); end
    fetch_vld = 1'b0;
    // Three levels ending at one address: two resolve now, third on the next match.
    push(16'h0090, 16'h0090, 16'd1);
    push(16'h0090, 16'h0090, 16'd1);
    push(16'h0090, 16'h0090, 16'd1);
    fetch_vld = 1'b1; faddr = 16'h0090; cyc();
    checks++; if (lc_depth !== 4'd1 || lc_redir !== 1'b0) begin failures++; $display("FAIL nest3_first got d=%0h r=%0b exp=1/0", lc_depth, lc_redir); end
    cyc();
    checks++; if (lc_depth !== 4'd0) begin failures++; $display("FAIL nest3_second got d=%0h exp=0", lc_depth); end
    fetch_vld = 1'b0;
  endtask

  task automatic test_zero();
    push(16'h1000, 16'hFFFF, 16'd0);
    checks++; if (lc_redir !== 1'b1 || lc_redir_add !== 16'h0000 || lc_depth !== 4'd0) begin failures++; $display("FAIL zero_skip got r=%0b a=%0h d=%0h exp=1/0/0", lc_redir, lc_redir_add, lc_depth); end
    cyc();
    checks++; if (lc_redir !== 1'b0) begin failures++; $display("FAIL zero_pulse got=%0b exp=0", lc_redir); end
  endtask

  task automatic test_ovf_unf();
    for (int i = 0; i < 5; i++) push(16'h0100, 16'(16'h0100 + i), 16'd5);
    checks++; if (lc_ovf !== 1'b1 || lc_depth !== 4'd4 || lc_laddr !== 16'h0103) begin failures++; $display("FAIL ovf got o=%0b d=%0h l=%0h exp=1/4/103", lc_ovf, lc_depth, lc_laddr); end
    for (int i = 0; i < 5; i++) pop();
    checks++; if (lc_unf !== 1'b1 || lc_depth !== 4'd0 || lc_ovf !== 1'b1) begin failures++; $display("FAIL unf got u=%0b d=%0h o=%0b exp=1/0/1", lc_unf, lc_depth, lc_ovf); end
    lc_clr = 1'b1; cyc(); lc_clr = 1'b0;
    checks++; if (lc_ovf !== 1'b0 || lc_unf !== 1'b0) begin failures++; $display("FAIL clr got o=%0b u=%0b exp=0/0", lc_ovf, lc_unf); end
    lc_clr = 1'b1; pop(); lc_clr = 1'b0;
    checks++; if (lc_unf !== 1'b1) begin failures++; $display("FAIL set_over_clr got=%0b exp=1", lc_unf); end
    lc_clr = 1'b1; cyc(); lc_clr = 1'b0;
  endtask

  task automatic test_stall_conflicts();
    push(16'h0010, 16'h0013, 16'd3);
    stall = 1'b1; fetch_vld = 1'b1; faddr = 16'h0013; lp_push = 1'b1; lp_cnt = 16'd2; cyc();
    checks++; if (lc_redir !== 1'b0 || lc_curlcntr !== 16'd3 || lc_depth !== 4'd1) begin failures++; $display("FAIL stall got r=%0b c=%0h d=%0h exp=0/3/1", lc_redir, lc_curlcntr, lc_depth); end
    stall = 1'b0; lp_push = 1'b0; cyc();
    checks++; if (lc_redir !== 1'b1 || lc_curlcntr !== 16'd2) begin failures++; $display("FAIL post_stall got r=%0b c=%0h exp=1/2", lc_redir, lc_curlcntr); end
    pop();
    checks++; if (lc_depth !== 4'd0 || lc_redir !== 1'b0) begin failures++; $display("FAIL pop_match got d=%0h r=%0b exp=0/0", lc_depth, lc_redir); end
    fetch_vld = 1'b0;
    push(16'h0040, 16'h0044, 16'd4);
    lp_pop = 1'b1; push(16'h0050, 16'h0058, 16'd7); lp_pop = 1'b0;
    checks++; if (lc_depth !== 4'd1 || lc_laddr !== 16'h0058 || lc_curlcntr !== 16'd7) begin failures++; $display("FAIL push_pop got d=%0h l=%0h c=%0h exp=1/58/7", lc_depth, lc_laddr, lc_curlcntr); end
    pop();
    push(16'h0060, 16'h0063, 16'd2);
    fetch_vld = 1'b1; faddr = 16'h0063; push(16'h0070, 16'h0073, 16'd0); fetch_vld = 1'b0;
    checks++; if (lc_redir !== 1'b1 || lc_redir_add !== 16'h0074 || lc_depth !== 4'd1 || lc_curlcntr !== 16'd1) begin failures++; $display("FAIL push_match got r=%0b a=%0h d=%0h c=%0h exp=1/74/1/1", lc_redir, lc_redir_add, lc_depth, lc_curlcntr); end
    pop();
  endtask

  task automatic test_reset_mid();
    push(16'h0080, 16'h008F, 16'd5);
    push(16'h0084, 16'h008F, 16'd5);
    rst = 1'b1; cyc(); rst = 1'b0;
    checks++; if (lc_depth !== 4'd0 || lc_curlcntr !== 16'h0 || lc_redir !== 1'b0 || lc_laddr !== 16'h0) begin failures++; $display("FAIL rst_mid got d=%0h c=%0h r=%0b l=%0h exp=0/0/0/0", lc_depth, lc_curlcntr, lc_redir, lc_laddr); end
    fetch_vld = 1'b1; faddr = 16'h008F; cyc(); fetch_vld = 1'b0;
    checks++; if (lc_redir !== 1'b0 || lc_depth !== 4'd0) begin failures++; $display("FAIL rst_mid_nomatch got r=%0b d=%0h exp=0/0", lc_redir, lc_depth); end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b0; stall = 1'b0; lp_push = 1'b0; lp_start_add = 16'h0; lp_end_add = 16'h0;
    lp_cnt = 16'h0; lp_pop = 1'b0; faddr = 16'h0; fetch_vld = 1'b0; lc_clr = 1'b0;
    test_reset();
    test_single();
    test_nested();
    test_zero();
    test_ovf_unf();
    test_stall_conflicts();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
